// File: rtl/uart_tx_fifo.sv
// Serial transmitter: DEPTH-entry write FIFO feeding a framer (start, 5..DATA_W data, parity/RS485 bit, 1-2 stop).
// Latency: a queued character starts on the first baud strobe after it is queued; tx_out and status are registered.
// Backpressure: wr_ready = !full; a write while full is dropped. The FIFO pops only at frame start.
module uart_tx_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  parameter int SIZE_W = $clog2(DATA_W + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     brgen,
  input  logic [1:0]               parity,
  input  logic                     stop2,
  input  logic [SIZE_W-1:0]        size,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     tx_out,
  output logic                     tx_en,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2
  } state_t;

  // ---------------------------------------------------------------- reset
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset asserts immediately and releases two clocks after the pin rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign fifo_count = count_q;

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Occupancy next state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- framer
  state_t            state_q;
  logic [DATA_W-1:0] word_q;
  logic [1:0]        par_q;
  logic              stop2_q;
  logic [SIZE_W-1:0] size_q, cnt_q, size_clamped;
  logic              tx_q, tx_en_q, done_q;
  logic              frame_end, start_ok;
  logic              nxt_bit, par_bit;
  logic [DATA_W-1:0] data_mask;

  // The last stop bit ends on this strobe; the next frame may start on it too.
  assign frame_end = brgen && ((state_q == S_STOP1 && !stop2_q) || state_q == S_STOP2);
  assign start_ok  = brgen && enable && !empty && (state_q == S_IDLE || frame_end);
  assign pop       = start_ok;

  // Clamp the requested character width into 5..DATA_W.
  always_comb begin
    size_clamped = size;
    if (size < SIZE_W'(5))           size_clamped = SIZE_W'(5);
    else if (size > SIZE_W'(DATA_W)) size_clamped = SIZE_W'(DATA_W);
  end

  // Next data bit and the parity/extra bit, computed from the latched word and size.
  always_comb begin
    nxt_bit   = 1'b1;
    data_mask = '0;
    par_bit   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == int'(cnt_q) + 1) nxt_bit = word_q[i];
      if (i < int'(size_q))     data_mask[i] = 1'b1;
    end
    case (par_q)
      2'd1: par_bit = ~^(word_q & data_mask);
      2'd2: par_bit = ^(word_q & data_mask);
      2'd3: begin
        // A full-width character has no spare bit above it, so the extra bit is 0.
        for (int i = 0; i < DATA_W; i++)
          if (i == int'(size_q)) par_bit = word_q[i];
      end
      default: par_bit = 1'b0;
    endcase
  end

  // Frame state machine; every line/status output is registered here.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      par_q   <= 2'd0;
      stop2_q <= 1'b0;
      size_q  <= SIZE_W'(5);
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        word_q  <= mem_q[rd_ptr_q];
        par_q   <= parity;
        stop2_q <= stop2;
        size_q  <= size_clamped;
        cnt_q   <= '0;
        tx_q    <= 1'b0;
        tx_en_q <= 1'b1;
        state_q <= S_START;
        if (frame_end) done_q <= 1'b1;
      end else if (brgen) begin
        case (state_q)
          S_IDLE: tx_q <= 1'b1;
          S_START: begin
            tx_q    <= word_q[0];
            state_q <= S_DATA;
          end
          S_DATA: begin
            if (cnt_q < size_q - SIZE_W'(1)) begin
              cnt_q <= cnt_q + SIZE_W'(1);
              tx_q  <= nxt_bit;
            end else if (par_q != 2'd0) begin
              tx_q    <= par_bit;
              state_q <= S_PAR;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_STOP1;
            end
          end
          S_PAR: begin
            tx_q    <= 1'b1;
            state_q <= S_STOP1;
          end
          S_STOP1: begin
            tx_q <= 1'b1;
            if (stop2_q) begin
              state_q <= S_STOP2;
            end else begin
              state_q <= S_IDLE;
              tx_en_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          S_STOP2: begin
            tx_q    <= 1'b1;
            state_q <= S_IDLE;
            tx_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
          default: begin
            tx_q    <= 1'b1;
            tx_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_out     = tx_q;
  assign tx_en      = tx_en_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line-level model predicts every output each clock,
// a table of hand-derived frames checks the line bit by bit, and short
// sequences cover FIFO full, back-to-back frames, mid-frame changes and reset.
module tb_uart_tx_fifo;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 8;
  localparam int SIZE_W = 4;

  logic              clock = 1'b0;
  logic              reset, enable, brgen, stop2, wr_valid;
  logic [1:0]        parity;
  logic [SIZE_W-1:0] size;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, tx_out, tx_en, busy, frame_done;
  logic [3:0]        fifo_count;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .brgen(brgen),
    .parity(parity), .stop2(stop2), .size(size), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .fifo_count(fifo_count),
    .tx_out(tx_out), .tx_en(tx_en), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued words, remaining bits of the frame on the line.
  logic [DATA_W-1:0] m_fifo[$];
  bit                m_line[$];
  bit                m_in_frame, m_tx, m_done;

  typedef struct {
    int          sz;
    int          par;
    bit          st2;
    logic [8:0]  word;
    int          len;
    logic [31:0] bits;   // bit i = line level during bit period i
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as a list of line levels, derived straight from the frame format.
  task automatic build_frame(input logic [DATA_W-1:0] w, input int sz_raw, input int par,
                             input bit st2, output int len, output logic [31:0] bits);
    int sz, ones;
    sz   = (sz_raw < 5) ? 5 : ((sz_raw > DATA_W) ? DATA_W : sz_raw);
    bits = '1;
    len  = 0;
    ones = 0;
    bits[len] = 1'b0; len++;
    for (int i = 0; i < sz; i++) begin
      bits[len] = w[i];
      ones = ones + int'(w[i]);
      len++;
    end
    if (par == 1)      begin bits[len] = ((ones % 2) == 0); len++; end
    else if (par == 2) begin bits[len] = ((ones % 2) == 1); len++; end
    else if (par == 3) begin bits[len] = (sz < DATA_W) ? w[sz] : 1'b0; len++; end
    bits[len] = 1'b1; len++;
    if (st2) begin bits[len] = 1'b1; len++; end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_line.delete();
    m_in_frame = 1'b0;
    m_tx       = 1'b1;
    m_done     = 1'b0;
  endtask

  // Advance the model by one clock using the inputs as they stand before the edge.
  task automatic model_step();
    bit          accept;
    int          len;
    logic [31:0] bits;
    accept = wr_valid && (m_fifo.size() < DEPTH);
    m_done = 1'b0;
    if (brgen) begin
      if (m_line.size() > 0) begin
        m_tx = m_line.pop_front();
      end else begin
        if (m_in_frame) begin m_done = 1'b1; m_in_frame = 1'b0; end
        if (enable && m_fifo.size() > 0) begin
          build_frame(m_fifo.pop_front(), int'(size), int'(parity), stop2, len, bits);
          m_tx = bits[0];
          for (int i = 1; i < len; i++) m_line.push_back(bits[i]);
          m_in_frame = 1'b1;
        end else begin
          m_tx = 1'b1;
        end
      end
    end
    if (accept) m_fifo.push_back(wr_data);
  endtask

  // One clock: model, edge, then compare all outputs on the falling edge.
  task automatic cycle();
    model_step();
    @(negedge clock);
    chk("tx_out",     int'(tx_out),     int'(m_tx));
    chk("tx_en",      int'(tx_en),      int'(m_in_frame));
    chk("busy",       int'(busy),       int'(m_in_frame));
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("fifo_count", int'(fifo_count), m_fifo.size());
    chk("wr_ready",   int'(wr_ready),   int'(m_fifo.size() < DEPTH));
  endtask

  task automatic strobe();
    brgen = 1'b1;
    cycle();
    brgen = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    cycle();
    wr_valid = 1'b0;
  endtask

  initial begin
    int pulses, done_at;

    vecs[0] = '{8,  2, 1'b0, 9'h0A5, 11, 32'h0000054A};  // even parity
    vecs[1] = '{7,  1, 1'b0, 9'h041, 10, 32'h00000382};  // odd parity
    vecs[2] = '{7,  1, 1'b1, 9'h041, 11, 32'h00000782};  // odd parity, 2 stop
    vecs[3] = '{8,  3, 1'b0, 9'h1F0, 11, 32'h000007E0};  // RS485 extra bit = 1
    vecs[4] = '{3,  0, 1'b0, 9'h0FF,  7, 32'h0000007E};  // size clamped up to 5
    vecs[5] = '{12, 3, 1'b0, 9'h1FF, 12, 32'h00000BFE};  // clamped to 9, extra bit 0
    vecs[6] = '{9,  2, 1'b1, 9'h100, 13, 32'h00001E00};  // full width, even, 2 stop
    vecs[7] = '{6,  1, 1'b0, 9'h1BF,  9, 32'h000001FE};  // upper bits ignored

    reset = 1'b1; enable = 1'b0; brgen = 1'b0; stop2 = 1'b0; wr_valid = 1'b0;
    parity = 2'd0; size = 4'd8; wr_data = '0;
    model_reset();

    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx_out",     int'(tx_out),     1);
    chk("rst_wr_ready",   int'(wr_ready),   1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_tx_en",      int'(tx_en),      0);
    chk("rst_frame_done", int'(frame_done), 0);
    reset = 1'b1;
    repeat (3) cycle();

    // Idle line under strobes with nothing queued
    enable = 1'b1;
    for (int s = 0; s < 20; s++) begin
      strobe();
      chk("idle_tx_out", int'(tx_out), 1);
      chk("idle_busy",   int'(busy),   0);
    end

    // Table of frames
    for (int v = 0; v < 8; v++) begin
      parity = 2'(vecs[v].par);
      size   = SIZE_W'(vecs[v].sz);
      stop2  = vecs[v].st2;
      push(vecs[v].word);
      for (int b = 0; b < vecs[v].len; b++) begin
        strobe();
        chk("vec_bit",  int'(tx_out), int'(vecs[v].bits[b]));
        chk("vec_txen", int'(tx_en),  1);
        repeat ($urandom_range(0, 2)) cycle();
      end
      strobe();
      chk("vec_done", int'(frame_done), 1);
      chk("vec_txen_off", int'(tx_en), 0);
      repeat (2) cycle();
    end

    // FIFO full: 9 writes with the transmitter disabled
    enable = 1'b0;
    for (int k = 0; k < 9; k++) push(DATA_W'(k * 37 + 3));
    chk("full_wr_ready",   int'(wr_ready),   0);
    chk("full_fifo_count", int'(fifo_count), 8);

    // Drain back to back with one bit per clock
    size = 4'd5; parity = 2'd0; stop2 = 1'b0; enable = 1'b1;
    brgen  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 57; k++) begin
      cycle();
      if (frame_done) pulses++;
      if (k < 56 && (k % 7) == 0) chk("b2b_start_bit", int'(tx_out), 0);
    end
    brgen = 1'b0;
    chk("b2b_frames",     pulses,            8);
    chk("b2b_fifo_count", int'(fifo_count), 0);
    chk("b2b_busy",       int'(busy),       0);

    // Size change and enable drop mid-frame: 8 data bits + even parity = 11 periods
    size = 4'd8; parity = 2'd2; stop2 = 1'b0;
    push(9'h0A5);
    strobe(); strobe(); strobe();
    size = 4'd5; parity = 2'd0; stop2 = 1'b1; enable = 1'b0;
    done_at = -1;
    for (int s = 3; s < 20 && done_at < 0; s++) begin
      strobe();
      if (frame_done) done_at = s;
    end
    chk("midframe_len", done_at, 11);
    enable = 1'b1;
    repeat (2) cycle();

    // Reset in the middle of the data bits
    size = 4'd8; parity = 2'd0; stop2 = 1'b0;
    push(9'h000);
    push(9'h0F0);
    repeat (4) strobe();
    chk("pre_reset_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx_out",     int'(tx_out),     1);
    chk("midrst_fifo_count", int'(fifo_count), 0);
    chk("midrst_busy",       int'(busy),       0);
    chk("midrst_tx_en",      int'(tx_en),      0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
    repeat (3) cycle();
    repeat (15) strobe();

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      brgen    = ((c / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = DATA_W'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      size     = SIZE_W'($urandom);
      parity   = 2'($urandom);
      stop2    = 1'($urandom);
      cycle();
    end
    wr_valid = 1'b0;
    enable   = 1'b1;
    brgen    = 1'b1;
    repeat (200) cycle();
    brgen = 1'b0;
    chk("final_fifo_count", int'(fifo_count), 0);
    chk("final_busy",       int'(busy),       0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised second-generation serial transmitter for the serial GPIO peripheral.
- Single system clock; the baud-rate generator supplies a one-cycle enable strobe (brgen) in the same clock domain, not a separate clock.
- A DEPTH-entry write FIFO with valid/ready handshake decouples the bus side from the line.
- Frame format is configurable per frame: 5..DATA_W data bits, odd/even/none/9th-bit (RS485 address) mode, 1 or 2 stop bits. Provides a driver-enable output for RS485 transceivers and a frame-done pulse.

Parameters:
DATA_W, 9, maximum character width including the RS485 extra bit; legal 6..16.
DEPTH, 8, number of FIFO entries; power of two, >= 2.
SIZE_W, $clog2(DATA_W+1), width of the size port (derived; do not override).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous active-low reset.
enable  in  1  transmitter enable; sampled only in IDLE.
brgen  in  1  one-clock baud strobe; one bit period = interval between strobes.
parity  in  2  0 = off, 1 = odd, 2 = even, 3 = RS485 extra bit.
stop2  in  1  1 = two stop bits.
size  in  SIZE_W  data bits per character.
wr_data  in  DATA_W  character to queue, LSB transmitted first.
wr_valid  in  1  write request.
wr_ready  out  1  FIFO can accept; equals !full.
fifo_count  out  $clog2(DEPTH)+1  entries currently queued.
tx_out  out  1  serial line, idle high.
tx_en  out  1  RS485 driver enable, high for the whole frame.
busy  out  1  frame in progress (state != IDLE).
frame_done  out  1  one-clock pulse at frame end.

Behaviour:
Reset (async assert, sync release):
- tx_out = 1; tx_en = 0; busy = 0; frame_done = 0; FIFO empty; fifo_count = 0; wr_ready = 1; state = IDLE.
- Reset mid-frame aborts the frame immediately and discards all queued data.

FIFO:
- A push occurs on a clock with wr_valid & wr_ready. No push when full; a wr_valid while full is ignored and the data is not captured.
- A pop occurs only at frame start.
- Push and pop in the same cycle leave fifo_count unchanged.
- Read and write pointers wrap modulo DEPTH.

Configuration latch:
- parity, stop2 and size are latched together with the popped word at frame start and held constant for the frame. Changes mid-frame affect only the next frame.
- size is clamped: < 5 becomes 5; > DATA_W becomes DATA_W.
- In parity mode 3 with latched size = DATA_W, the extra bit is sent as 0.

State machine: IDLE, START, DATA, PAR, STOP1, STOP2. A bit counter is used in DATA. All transitions other than IDLE-entry checks occur only on clocks with brgen = 1; tx_out is registered and changes only on those clocks.
- IDLE: if brgen & enable & FIFO non-empty, then pop, latch config, tx_out <= 0, tx_en <= 1, bit counter = 0, go to START. Otherwise tx_out = 1.
- START -> DATA: drive word[0].
- DATA: at each strobe, if counter < size-1, increment and drive word[counter+1]. Otherwise, if parity != 0 go to PAR, else go to STOP1 and drive 1.
- PAR: drives the parity/extra bit, then goes to STOP1.
  - Odd: the bit makes the count of ones in data+parity odd.
  - Even: the bit makes that count even.
  - Mode 3: the bit is word[size].
- STOP1: drives 1. If stop2, go to STOP2. Otherwise, at the next strobe, go to IDLE with frame_done = 1 for that clock and tx_en <= 0.
- STOP2: drives 1. At the next strobe, go to IDLE with frame_done = 1 and tx_en <= 0.
- Back-to-back frames: the IDLE exit condition is evaluated on the same strobe that ends the stop bit, so a queued character's start bit follows with no idle gap.

Control and status:
- enable low has no effect on a frame in progress; the frame completes.
- brgen held high continuously is legal: one bit per clock.

Frame length: 1 + size + (parity != 0) + 1 + stop2 bit periods.

Test Plan:
- Reset value: with reset low, tx_out = 1, wr_ready = 1, fifo_count = 0. Then release reset, push nothing, and issue 20 strobes: tx_out stays 1 and busy stays 0.
- Even parity: size = 8, parity = 2, stop2 = 0, push 0x0A5. The line must show 0,1,0,1,0,0,1,0,1,0,1 over 11 periods, then frame_done pulses once.
- Odd parity: size = 7, parity = 1, push 0x041. Data bits are 1,0,0,0,0,0,1 and the parity bit is 1. Repeat with stop2 = 1: the frame length must be 11 periods.
- RS485 mode: size = 8, parity = 3, push 0x1F0. The line must show 0, 0,0,0,0,1,1,1,1, 1, 1, and tx_en must be high from the start-bit strobe until frame_done.
- FIFO limits: DEPTH = 8, enable = 0, push 9 words. The first 8 are accepted, wr_ready = 0, fifo_count = 8, and the 9th is not stored. Then set enable = 1 with size = 5, parity = 0: 8 back-to-back 7-period frames are sent with no idle gap, and fifo_count finishes at 0.
- Disruptions: change size mid-frame and confirm the current frame is unaffected. Deassert enable mid-frame and confirm the frame completes. Assert reset mid-DATA: tx_out = 1 immediately and fifo_count = 0.
